// File: rtl/tinyrv_fetch_responder.sv
// rtl/tinyrv_fetch_responder.sv - single-stage fetch/load responder with byte-serial program loader
module tinyrv_fetch_responder #(
  parameter int AW = 4
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          req_valid,
  output logic          req_ready,
  input  logic [15:0]   req_addr,
  output logic          rsp_valid,
  input  logic          rsp_ready,
  output logic [15:0]   rsp_data,
  output logic          rsp_err,
  input  logic          ld_valid,
  input  logic [7:0]    ld_data,
  input  logic          ld_clear,
  output logic [AW-1:0] ld_ptr
);

  localparam int DEPTH = 2 ** AW;

  typedef enum logic {
    EMPTY = 1'b0,
    FULL  = 1'b1
  } state_e;

  state_e        state_q, state_d;
  logic [15:0]   rsp_data_q, rsp_data_d;
  logic          rsp_err_q, rsp_err_d;
  logic [15:0]   mem_q [DEPTH];
  logic [AW-1:0] ld_ptr_q;
  logic          ld_lo_q;
  logic [7:0]    ld_hi_q;
  logic          req_fire;
  logic          in_range;
  logic          wr_en;

  assign rsp_valid = (state_q == FULL);
  assign req_ready = !rsp_valid | rsp_ready;
  assign req_fire  = req_valid & req_ready;
  // Upper address bits must be zero; no aliasing into the small memory.
  assign in_range  = (req_addr[15:AW] == '0);
  assign rsp_data  = rsp_data_q;
  assign rsp_err   = rsp_err_q;
  assign ld_ptr    = ld_ptr_q;
  // A word is written only when the low byte arrives and no clear overrides it.
  assign wr_en     = ld_valid & !ld_clear & ld_lo_q;

  // Response slot register: state plus held response payload.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= EMPTY;
      rsp_data_q <= 16'h0000;
      rsp_err_q  <= 1'b0;
    end else begin
      state_q    <= state_d;
      rsp_data_q <= rsp_data_d;
      rsp_err_q  <= rsp_err_d;
    end
  end

  // Next state: accepting a request fills the slot, a drained slot with no new request empties.
  always_comb begin
    state_d    = state_q;
    rsp_data_d = rsp_data_q;
    rsp_err_d  = rsp_err_q;
    if (req_fire) begin
      state_d    = FULL;
      rsp_data_d = in_range ? mem_q[req_addr[AW-1:0]] : 16'h0000;
      rsp_err_d  = !in_range;
    end else if (state_q == FULL && rsp_ready) begin
      state_d = EMPTY;
    end
  end

  // Word memory; the read above sees pre-write contents on a same-cycle write.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < DEPTH; i++) begin
        mem_q[i] <= 16'h0000;
      end
    end else if (wr_en) begin
      mem_q[ld_ptr_q] <= {ld_hi_q, ld_data};
    end
  end

  // Load pointer and hi/lo byte toggle; clear wins over a coincident byte.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ld_ptr_q <= '0;
      ld_lo_q  <= 1'b0;
      ld_hi_q  <= 8'h00;
    end else if (ld_clear) begin
      ld_ptr_q <= '0;
      ld_lo_q  <= 1'b0;
    end else if (ld_valid) begin
      if (!ld_lo_q) begin
        ld_hi_q <= ld_data;
        ld_lo_q <= 1'b1;
      end else begin
        ld_ptr_q <= ld_ptr_q + 1'b1;
        ld_lo_q  <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_tinyrv_fetch_responder.sv
// tb/tb_tinyrv_fetch_responder.sv - directed and randomized checks against a behavioural model
module tb_tinyrv_fetch_responder;

  localparam int AW    = 4;
  localparam int DEPTH = 2 ** AW;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          req_valid;
  logic          req_ready;
  logic [15:0]   req_addr;
  logic          rsp_valid;
  logic          rsp_ready;
  logic [15:0]   rsp_data;
  logic          rsp_err;
  logic          ld_valid;
  logic [7:0]    ld_data;
  logic          ld_clear;
  logic [AW-1:0] ld_ptr;

  int checks = 0;
  int errors = 0;

  // behavioural model
  logic [15:0] m_mem [DEPTH];
  int          m_ptr;
  bit          m_have_hi;
  logic [7:0]  m_hi;
  bit          m_valid;
  logic [15:0] m_data;
  bit          m_err;

  tinyrv_fetch_responder #(.AW(AW)) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .req_valid(req_valid),
    .req_ready(req_ready),
    .req_addr (req_addr),
    .rsp_valid(rsp_valid),
    .rsp_ready(rsp_ready),
    .rsp_data (rsp_data),
    .rsp_err  (rsp_err),
    .ld_valid (ld_valid),
    .ld_data  (ld_data),
    .ld_clear (ld_clear),
    .ld_ptr   (ld_ptr)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    for (int i = 0; i < DEPTH; i++) m_mem[i] = 16'h0000;
    m_ptr = 0; m_have_hi = 0; m_hi = 8'h00;
    m_valid = 0; m_data = 16'h0000; m_err = 0;
  endtask

  // One clock: apply inputs, check req_ready, advance model, check registered outputs.
  task automatic step(input bit rv, input logic [15:0] ra, input bit rr,
                      input bit lv, input logic [7:0] ld, input bit lc);
    bit ready_exp;
    req_valid = rv; req_addr = ra; rsp_ready = rr;
    ld_valid = lv; ld_data = ld; ld_clear = lc;
    #1;
    ready_exp = !m_valid || rr;
    chk("req_ready", req_ready, ready_exp);
    if (rv && ready_exp) begin
      m_valid = 1;
      if (ra < DEPTH) begin m_data = m_mem[ra]; m_err = 0; end
      else            begin m_data = 16'h0000;  m_err = 1; end
    end else if (m_valid && rr) begin
      m_valid = 0;
    end
    if (lc) begin
      m_ptr = 0; m_have_hi = 0;
    end else if (lv) begin
      if (!m_have_hi) begin m_hi = ld; m_have_hi = 1; end
      else begin
        m_mem[m_ptr] = {m_hi, ld};
        m_ptr = (m_ptr + 1) % DEPTH;
        m_have_hi = 0;
      end
    end
    @(posedge clk);
    #1;
    chk("rsp_valid", rsp_valid, m_valid);
    chk("rsp_data", rsp_data, m_data);
    chk("rsp_err", rsp_err, m_err);
    chk("ld_ptr", ld_ptr, m_ptr);
  endtask

  task automatic load_word(input logic [15:0] w);
    step(0, 16'h0, 1, 1, w[15:8], 0);
    step(0, 16'h0, 1, 1, w[7:0], 0);
  endtask

  initial begin
    logic [15:0] words [33];
    logic [15:0] a;

    rst_n = 0; req_valid = 0; req_addr = 0; rsp_ready = 0;
    ld_valid = 0; ld_data = 0; ld_clear = 0;
    model_reset();
    #2;
    chk("rst_rsp_valid", rsp_valid, 0);
    chk("rst_req_ready", req_ready, 1);
    chk("rst_rsp_data", rsp_data, 0);
    chk("rst_rsp_err", rsp_err, 0);
    chk("rst_ld_ptr", ld_ptr, 0);
    // inputs active during reset are not captured
    req_valid = 1; ld_valid = 1; ld_data = 8'hEE;
    @(posedge clk); #1;
    chk("rst_no_capture_valid", rsp_valid, 0);
    chk("rst_no_capture_ptr", ld_ptr, 0);
    req_valid = 0; ld_valid = 0;
    @(posedge clk); #1;
    rst_n = 1;

    // load 1234, ABCD; back-to-back reads
    step(0, 0, 1, 1, 8'h12, 0);
    step(0, 0, 1, 1, 8'h34, 0);
    step(0, 0, 1, 1, 8'hAB, 0);
    step(0, 0, 1, 1, 8'hCD, 0);
    chk("load2_ptr", ld_ptr, 2);
    step(1, 16'h0000, 1, 0, 0, 0);
    chk("read0_data", rsp_data, 16'h1234);
    step(1, 16'h0001, 1, 0, 0, 0);
    chk("read1_data", rsp_data, 16'hABCD);
    chk("read1_valid", rsp_valid, 1);
    step(0, 0, 1, 0, 0, 0);

    // out of range
    step(1, 16'h0010, 1, 0, 0, 0);
    chk("oor_err", rsp_err, 1);
    chk("oor_data", rsp_data, 16'h0000);
    step(1, 16'h8003, 1, 0, 0, 0);
    chk("oor_high_err", rsp_err, 1);

    // backpressure: held response stable while address toggles
    step(1, 16'h0001, 1, 0, 0, 0);
    for (int i = 0; i < 5; i++) step(1'($urandom), 16'($urandom), 0, 0, 0, 0);
    chk("hold_data", rsp_data, 16'hABCD);
    step(0, 0, 1, 0, 0, 0);
    chk("drain_empty", rsp_valid, 0);
    step(1, 16'h0000, 0, 0, 0, 0);
    step(1, 16'h0001, 1, 0, 0, 0);
    chk("fullthru_data", rsp_data, 16'hABCD);
    step(0, 0, 1, 0, 0, 0);

    // 33 words with wrap
    step(0, 0, 1, 0, 0, 1);
    for (int i = 0; i < 33; i++) begin
      words[i] = 16'($urandom);
      load_word(words[i]);
      if (i == 15) chk("wrap_ptr0", ld_ptr, 0);
    end
    chk("wrap_ptr1", ld_ptr, 1);
    step(1, 16'h0000, 1, 0, 0, 0);
    chk("wrap_word", rsp_data, words[32]);
    step(1, 16'h000F, 1, 0, 0, 0);
    chk("wrap_word15", rsp_data, words[31]);

    // clear discards partial byte and coincident byte
    step(0, 0, 1, 0, 0, 1);
    step(0, 0, 1, 1, 8'h55, 0);
    step(0, 0, 1, 1, 8'h99, 1);
    step(0, 0, 1, 1, 8'h66, 0);
    // same-cycle write and read of addr 0 returns old contents
    step(1, 16'h0000, 1, 1, 8'h77, 0);
    chk("rd_during_wr", rsp_data, words[32]);
    step(1, 16'h0000, 1, 0, 0, 0);
    chk("clear_word", rsp_data, 16'h6677);
    chk("clear_ptr", ld_ptr, 1);

    // randomized concurrent traffic
    for (int i = 0; i < 400; i++) begin
      a = ($urandom_range(0, 7) == 0) ? 16'($urandom) : 16'($urandom_range(0, DEPTH - 1));
      step(1'($urandom), a, 1'($urandom), 1'($urandom), 8'($urandom),
           $urandom_range(0, 15) == 0);
    end

    // asynchronous reset while FULL and mid-word
    step(0, 0, 1, 0, 0, 1);
    step(1, 16'h0000, 0, 1, 8'hA5, 0);
    chk("pre_rst_valid", rsp_valid, 1);
    #2;
    rst_n = 0;
    #1;
    chk("arst_valid", rsp_valid, 0);
    chk("arst_ready", req_ready, 1);
    chk("arst_data", rsp_data, 0);
    chk("arst_ptr", ld_ptr, 0);
    model_reset();
    req_valid = 0; ld_valid = 0;
    @(posedge clk); #1;
    rst_n = 1;
    step(0, 0, 1, 1, 8'h3C, 0);
    step(1, 16'h0000, 1, 1, 8'hC3, 0);
    chk("post_rst_read", rsp_data, 16'h0000);
    step(1, 16'h0000, 1, 0, 0, 0);
    chk("post_rst_load", rsp_data, 16'h3CC3);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
